// File: rtl/block_serial_subtractor.sv
// ============================================================================
// block_serial_subtractor
// ----------------------------------------------------------------------------
// Multi-cycle unsigned subtractor: diff = a - b - bin (mod 2^N), bout = borrow
// out of bit N-1. The operands are processed BLOCK_SIZE bits per clock, from
// the least significant block upward. Each block has a borrow-skip mux: when
// every bit pair in the block is equal, the block's borrow out is its borrow
// in, which shortens the critical path. The result does not depend on which
// path is taken.
//
// Parameters:
//   N           operand width in bits (>= 1)
//   BLOCK_SIZE  bits processed per clock (>= 1); NB = ceil(N / BLOCK_SIZE)
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   operands valid
//   in_ready   out  operands can be accepted (only in IDLE)
//   a          in   [N]  minuend
//   b          in   [N]  subtrahend
//   bin        in   borrow in
//   out_valid  out  result valid (DONE state)
//   out_ready  in   consumer accepts the result
//   diff       out  [N]  a - b - bin, modulo 2^N
//   bout       out  borrow out (1 when a < b + bin, unsigned)
//   skip_cnt   out  [$clog2(NB+1)]  blocks of the current operation that took
//                   the skip path (only when BSS_SKIP_CNT_EN is defined)
//
// Build option:
//   BSS_SKIP_CNT_EN  adds the skip_cnt output and its counter. Without it the
//                    port and the counter are absent; function is unchanged.
//
// Timing: out_valid rises exactly NB cycles after the accepting edge. With
// out_ready held high a new result is available every NB+1 cycles, because
// in_ready is low in DONE and only returns the cycle after the handoff.
// ============================================================================
module block_serial_subtractor #(
    parameter int N          = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          bin,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  diff,
    output logic          bout
`ifdef BSS_SKIP_CNT_EN
    ,
    output logic [$clog2((N + BLOCK_SIZE - 1) / BLOCK_SIZE + 1) - 1:0] skip_cnt
`endif
);

    // ------------------------------------------------------------------------
    // Derived sizes
    // ------------------------------------------------------------------------
    localparam int NB = (N + BLOCK_SIZE - 1) / BLOCK_SIZE;
    localparam int W  = NB * BLOCK_SIZE;
    localparam int IW = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    // ------------------------------------------------------------------------
    // Datapath storage
    // ------------------------------------------------------------------------
    // Operands are held zero-extended to W bits and shifted right one block
    // per cycle, so the block being processed is always in the low slice.
    // Result blocks enter at the top of diff_sh and after NB shifts block 0
    // sits at bit 0. This avoids a wide index-driven read/write mux.
    logic [W-1:0]          a_sh;
    logic [W-1:0]          b_sh;
    logic [W-1:0]          diff_sh;
    logic [W-1:0]          diff_next;
    logic                  borrow;
    logic [IW-1:0]         idx;

    logic [BLOCK_SIZE-1:0] a_blk;
    logic [BLOCK_SIZE-1:0] b_blk;
    logic [BLOCK_SIZE-1:0] blk_diff;
    logic                  ripple_bout;
    logic                  propagate;
    logic                  blk_bout;

    logic                  accept;
    logic                  step;

    assign a_blk  = a_sh[BLOCK_SIZE-1:0];
    assign b_blk  = b_sh[BLOCK_SIZE-1:0];
    assign accept = (state == IDLE) && in_valid;
    assign step   = (state == RUN);

    // ------------------------------------------------------------------------
    // One block of ripple-borrow subtraction
    // ------------------------------------------------------------------------
    always_comb begin
        logic br;
        br       = borrow;
        blk_diff = '0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            blk_diff[i] = a_blk[i] ^ b_blk[i] ^ br;
            br          = (~a_blk[i] & b_blk[i]) | (~(a_blk[i] ^ b_blk[i]) & br);
        end
        ripple_bout = br;
    end

    // Borrow-skip mux: equal bit pairs pass the incoming borrow straight
    // through, which is also what the ripple chain computes in that case.
    assign propagate = (a_blk == b_blk);
    assign blk_bout  = propagate ? borrow : ripple_bout;

    // Next value of the result shift register: shift down one block and
    // insert the freshly computed block at the top.
    always_comb begin
        diff_next                        = diff_sh >> BLOCK_SIZE;
        diff_next[W-1 -: BLOCK_SIZE]     = blk_diff;
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (in_valid)          next_state = RUN;
            RUN:  if (idx == LAST_IDX)   next_state = DONE;
            DONE: if (out_ready)         next_state = IDLE;
            default:                     next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // diff_sh is not cleared on accept: it only matters while out_valid is
    // high, and by then every block has been overwritten. The borrow register
    // doubles as bout once the last block (including zero pad bits, which
    // simply pass the borrow) has been processed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh    <= '0;
            b_sh    <= '0;
            diff_sh <= '0;
            borrow  <= 1'b0;
            idx     <= '0;
        end else if (accept) begin
            a_sh    <= W'(a);
            b_sh    <= W'(b);
            borrow  <= bin;
            idx     <= '0;
        end else if (step) begin
            a_sh    <= a_sh >> BLOCK_SIZE;
            b_sh    <= b_sh >> BLOCK_SIZE;
            diff_sh <= diff_next;
            borrow  <= blk_bout;
            idx     <= idx + IW'(1);
        end
    end

    assign diff = diff_sh[N-1:0];
    assign bout = borrow;

`ifdef BSS_SKIP_CNT_EN
    // ------------------------------------------------------------------------
    // Skip-path counter
    // ------------------------------------------------------------------------
    localparam int CW = $clog2(NB + 1);

    logic [CW-1:0] skip_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skip_r <= '0;
        end else if (accept) begin
            skip_r <= '0;
        end else if (step && propagate) begin
            skip_r <= skip_r + CW'(1);
        end
    end

    assign skip_cnt = skip_r;
`endif

endmodule
